// File: rtl/mem_bus_responder.sv
// Memory-side responder: one request at a time, optional wait states, range check, 1-cycle-latency RAM port.
// Optional store write-protection below PROT_LIMIT is enabled by defining MEM_RESP_WPROT_EN.
module mem_bus_responder #(
    parameter int                ADDR_W      = 16,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] PROT_LIMIT  = 'h0040
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              ack,
    output logic [15:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we,
    input  logic [15:0]       ram_dout,
    output logic [2:0]        dbg_state_o
);

    // Handshake: req is sampled only in IDLE; ack is a single-cycle pulse and
    // rdata/err are valid while ack=1; requester holds addr/we/wdata until ack.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
`ifdef MEM_RESP_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         din_q, din_d;
    logic                we_q, we_d;
    logic                rej_q, rej_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic range_rej;
    logic prot_rej;
    logic reject_in;

    // Unsigned compare over the full address width, one extra bit so DEPTH never wraps.
    assign range_rej = ({1'b0, addr} >= DEPTH_X);
    assign prot_rej  = WPROT_EN && we && (addr < PROT_LIMIT);
    assign reject_in = range_rej | prot_rej;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            rej_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            rej_q   <= rej_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = we_q;
        rej_d   = rej_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = addr;
                    din_d  = wdata;
                    we_d   = we;
                    rej_d  = reject_in;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (WAIT_STATES > 0) begin
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Stores leave rdata holding the previous read value.
                if (rej_q) begin
                    rdata_d = 16'h0000;
                end else if (!we_q) begin
                    rdata_d = ram_dout;
                end
                err_d   = rej_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack         = (state_q == S_RESP);
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign ram_addr    = addr_q;
    assign ram_din     = din_q;
    assign ram_we      = (state_q == S_ACCESS) && we_q && !rej_q;
    assign dbg_state_o = state_q;

endmodule
